// File: rtl/data_mem_responder.sv
// Load/store responder over a word-organised, byte-writable data memory with a fixed access latency.
// Optional DMEM_STATS_EN adds load/store/error event counters.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_errs
`endif
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_rd_word;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [IDX_W-1:0] w_idx;
    logic [31:0] w_word_idx;
    logic        w_in_range;
    logic        w_f3_ok;
    logic        w_misalign;
    logic        w_err;
    logic        w_do_write;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_lanes;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_rdata;

    // FSM: state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // WAIT spans LATENCY cycles so resp_valid rises LATENCY+1 edges after accept.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = 4'd0;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'(LATENCY - 1)) begin
                    w_state_next = S_EXEC;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_EXEC: w_state_next = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && req_valid) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
        end
    end

    // Decode of the captured request
    assign w_word_idx = {2'b00, r_addr[31:2]};
    assign w_in_range = (w_word_idx < 32'(DEPTH_WORDS));
    assign w_idx      = r_addr[IDX_W+1:2];

    always_comb begin
        w_f3_ok = 1'b0;
        if (r_we) w_f3_ok = (r_funct3 == 3'b000) || (r_funct3 == 3'b001) || (r_funct3 == 3'b010);
        else      w_f3_ok = (r_funct3 == 3'b000) || (r_funct3 == 3'b001) || (r_funct3 == 3'b010)
                         || (r_funct3 == 3'b100) || (r_funct3 == 3'b101);
    end

    assign w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0])
                     || ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_err      = !w_f3_ok || w_misalign || !w_in_range;
    assign w_do_write = (r_state == S_EXEC) && r_we && !w_err && !rst;

    // Per-lane byte enable and right-aligned store data replicated into place
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_be[gi] = (r_funct3[1:0] == 2'b10)
                           || ((r_funct3[1:0] == 2'b01) && (r_addr[1] == 1'(gi / 2)))
                           || ((r_funct3[1:0] == 2'b00) && (r_addr[1:0] == 2'(gi)));
            assign w_wdata_lanes[8*gi +: 8] = (r_funct3[1:0] == 2'b10) ? r_wdata[8*gi +: 8] :
                                              (r_funct3[1:0] == 2'b01) ? r_wdata[8*(gi%2) +: 8] :
                                                                         r_wdata[7:0];
        end
    endgenerate

    // Block RAM: byte-enable write, registered read; read word is settled before EXEC.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
            end
        end
        r_rd_word <= r_mem[w_idx];
    end

    assign w_shift = r_rd_word >> {r_addr[1:0], 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = r_addr[1] ? r_rd_word[31:16] : r_rd_word[15:0];

    always_comb begin
        w_load = 32'd0;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = r_rd_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    assign w_rdata = (r_we || w_err) ? 32'd0 : w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_resp_rdata <= w_rdata;
            r_resp_err   <= w_err;
        end
    end

    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

`ifdef DMEM_STATS_EN
    logic [31:0] r_stat_loads;
    logic [31:0] r_stat_stores;
    logic [31:0] r_stat_errs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_loads  <= 32'd0;
            r_stat_stores <= 32'd0;
            r_stat_errs   <= 32'd0;
        end else if (r_state == S_EXEC) begin
            if (w_err)     r_stat_errs   <= r_stat_errs + 32'd1;
            else if (r_we) r_stat_stores <= r_stat_stores + 32'd1;
            else           r_stat_loads  <= r_stat_loads + 32'd1;
        end
    end

    assign stat_loads  = r_stat_loads;
    assign stat_stores = r_stat_stores;
    assign stat_errs   = r_stat_errs;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder; one line printed per transaction.
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
`ifdef DMEM_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_errs;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
`ifdef DMEM_STATS_EN
        ,
        .stat_loads (stat_loads),
        .stat_stores(stat_stores),
        .stat_errs  (stat_errs)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Issue one request and wait for resp_valid; leaves the response pending.
    task automatic issue_wait(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                              output bit got);
        int n;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (resp_valid) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL resp_timeout actual=none required=resp_valid");
        end else begin
            chk("latency", 32'(n), 32'(LAT + 1));
            chk("rdata", resp_rdata, exp_rd);
            chk("err", {31'd0, resp_err}, {31'd0, exp_err});
        end
        $display("txn we=%0d addr=%h wdata=%h f3=%0d -> rdata=%h err=%0d lat=%0d",
                 we, addr, wdata, f3, resp_rdata, resp_err, n);
    endtask

    task automatic handshake();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("resp_valid_after_hs", {31'd0, resp_valid}, 32'd0);
        chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err);
        bit got;
        issue_wait(we, addr, wdata, f3, exp_rd, exp_err, got);
        if (got) handshake();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    endtask

    initial begin
        bit got;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h11,  32'hFFFFFF7F, 3'b000, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD7FEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 1'b0};
        vecs[5]  = '{1'b0, 32'h13,  32'h0,        3'b100, 32'h000000DE, 1'b0};
        vecs[6]  = '{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 1'b0};
        vecs[7]  = '{1'b0, 32'h12,  32'h0,        3'b101, 32'h0000DEAD, 1'b0};
        vecs[8]  = '{1'b0, 32'h11,  32'h0,        3'b000, 32'h0000007F, 1'b0};
        vecs[9]  = '{1'b0, 32'h12,  32'h0,        3'b010, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 32'h11,  32'h0000AAAA, 3'b001, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD7FEF, 1'b0};
        vecs[12] = '{1'b0, 32'h1000, 32'h0,       3'b010, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 32'h10,  32'h11111111, 3'b100, 32'h0,        1'b1};
        vecs[15] = '{1'b1, 32'h12,  32'hFFFF1234, 3'b001, 32'h0,        1'b0};
        vecs[16] = '{1'b0, 32'h10,  32'h0,        3'b010, 32'h12347FEF, 1'b0};
        vecs[17] = '{1'b0, 32'h10,  32'h0,        3'b001, 32'h00007FEF, 1'b0};
        vecs[18] = '{1'b1, 32'hFFC, 32'h0BADCAFE, 3'b010, 32'h0,        1'b0};
        vecs[19] = '{1'b0, 32'hFFC, 32'h0,        3'b010, 32'h0BADCAFE, 1'b0};
        vecs[20] = '{1'b1, 32'h20,  32'hCAFEF00D, 3'b010, 32'h0,        1'b0};
        vecs[21] = '{1'b0, 32'h10,  32'h0,        3'b110, 32'h0,        1'b1};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_funct3 = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // resp_ready while idle must be ignored
        @(negedge clk) resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("idle_rr_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_rr_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 22; i++)
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
                    vecs[i].exp_rdata, vecs[i].exp_err);

        // Backpressure: response held stable with resp_ready low
        issue_wait(1'b0, 32'h10, 32'h0, 3'b010, 32'h12347FEF, 1'b0, got);
        if (got) begin
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
                chk("bp_rdata", resp_rdata, 32'h12347FEF);
                chk("bp_err", {31'd0, resp_err}, 32'd0);
                chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            end
            handshake();
        end

        // Reset while a store sits in WAIT: store must never commit
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 chk_reset_outputs("rst_wait");
        @(negedge clk) rst = 1'b0;
        $display("txn reset during WAIT of SW 0x20");
        run_txn(1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);

        // Reset while a load response is pending clears the outputs
        issue_wait(1'b0, 32'h10, 32'h0, 3'b010, 32'h12347FEF, 1'b0, got);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 chk_reset_outputs("rst_resp");
        @(negedge clk) rst = 1'b0;
        $display("txn reset during RESP of LW 0x10");

`ifdef DMEM_STATS_EN
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        run_txn(1'b0, 32'h10, 32'h0, 3'b010, 32'h12347FEF, 1'b0);
        run_txn(1'b0, 32'h11, 32'h0, 3'b000, 32'h0000007F, 1'b0);
        run_txn(1'b0, 32'h12, 32'h0, 3'b101, 32'h00001234, 1'b0);
        run_txn(1'b1, 32'h30, 32'h000000AB, 3'b000, 32'h0, 1'b0);
        run_txn(1'b1, 32'h34, 32'h01020304, 3'b010, 32'h0, 1'b0);
        run_txn(1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1);
        chk("stat_loads", stat_loads, 32'd3);
        chk("stat_stores", stat_stores, 32'd2);
        chk("stat_errs", stat_errs, 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("stat_loads_rst", stat_loads, 32'd0);
        chk("stat_stores_rst", stat_stores, 32'd0);
        chk("stat_errs_rst", stat_errs, 32'd0);
        @(negedge clk) rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
